// File: rtl/product_bcd_converter_pkg.sv
// Shared types and helpers for the product binary-to-BCD converter.
// Holds the FSM state encoding, the BCD digit width and elaboration-time sizing helpers.
package product_bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  localparam int unsigned BCD_DIGIT_W = 4;

  // A 1-bit input still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/product_bcd_converter_if.sv
// Start/busy/done handshake and data bus between the multiplier side and the BCD converter.
// The master issues start/bin; the slave returns the packed BCD result and status.
interface product_bcd_converter_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic [4*DIGITS-1:0] bcd;
  logic                busy;
  logic                done;

  modport master (output start, output bin, input bcd, input busy, input done);
  modport slave  (input start, input bin, output bcd, output busy, output done);
endinterface

// File: rtl/product_bcd_converter_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import product_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_DIGIT_W'(5)) ? i_digit + BCD_DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// bcd only updates on the completing edge so the display never shows partial digits.
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  product_bcd_converter_if.slave  bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (!(pow10(DIGITS) > ((64'd1 << WIDTH) - 64'd1))) begin : g_size_check
    $error("product_bcd_converter: DIGITS=%0d cannot hold a %0d-bit value", DIGITS, WIDTH);
  end

  bcd_state_t       r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BCD_W-1:0] r_scratch;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_scratch_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjust first, then shift the binary MSB into the scratch LSB.
  assign w_scratch_nxt = {w_adj[BCD_W-2:0], r_bin[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_scratch <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_bin     <= bus.bin;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end else begin
            r_busy <= 1'b0;
          end
        end
        SHIFT: begin
          r_scratch <= w_scratch_nxt;
          r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_bcd   <= w_scratch_nxt;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.bcd  = r_bcd;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: directed handshake cases plus a
// randomized sweep compared against a decimal-arithmetic reference model.
module tb_product_bcd_converter;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned LAT    = WIDTH;

  logic clk = 1'b0;
  logic reset;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned done_cnt = 0;
  int unsigned accepted = 0;
  logic [4*DIGITS-1:0] prev_bcd;

  always #5 clk = ~clk;

  product_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
  end

  function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call just after the accepting edge (elapsed edges since then already counted).
  task automatic wait_done(input int unsigned elapsed, input int unsigned v, input string tag);
    int unsigned cyc;
    logic [4*DIGITS-1:0] exp;
    exp = ref_bcd(v);
    cyc = elapsed;
    while (!bus.done && cyc < 60) begin
      if (bus.bcd !== prev_bcd || bus.busy !== 1'b1) begin
        check_eq({tag, "_hold_bcd"}, 32'(bus.bcd), 32'(prev_bcd));
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
      end
      tick();
      cyc++;
    end
    check_eq({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    check_eq({tag, "_latency"}, cyc, LAT);
    check_eq({tag, "_bcd"}, 32'(bus.bcd), 32'(exp));
    check_eq({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    prev_bcd = exp;
    tick();
    check_eq({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic convert(input int unsigned v, input string tag);
    bus.bin   = WIDTH'(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    accepted++;
    check_eq({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    wait_done(0, v, tag);
  endtask

  initial begin
    int unsigned v;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    prev_bcd  = '0;
    tick();
    tick();
    check_eq("rst_bcd", 32'(bus.bcd), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    tick();

    convert(0, "zero");
    convert(65025, "p255sq");
    convert(65535, "max");

    // Second start during SHIFT must be ignored along with its new bin.
    bus.bin   = 16'd12345;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    accepted++;
    repeat (4) tick();
    bus.bin   = 16'd999;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(5, 12345, "ignore");

    // Start held high: next acceptance on the first IDLE edge.
    bus.bin   = 16'd9;
    bus.start = 1'b1;
    tick();
    accepted++;
    bus.bin = 16'd10;
    wait_done(0, 9, "b2b_a");
    tick();
    accepted++;
    check_eq("b2b_busy_reaccept", 32'(bus.busy), 32'd1);
    wait_done(0, 10, "b2b_b");
    bus.start = 1'b0;
    tick();
    check_eq("b2b_idle", 32'(bus.busy), 32'd0);

    // Reset mid-conversion aborts without a done pulse.
    convert(42, "pre42");
    bus.bin   = 16'd500;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    prev_bcd = '0;
    check_eq("abort_bcd", 32'(bus.bcd), 32'd0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    repeat (20) tick();
    check_eq("abort_quiet_bcd", 32'(bus.bcd), 32'd0);
    convert(500, "restart");

    // Reset wins over a simultaneous start.
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.bin   = 16'd777;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    prev_bcd  = '0;
    tick();
    check_eq("rst_vs_start_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_vs_start_bcd", 32'(bus.bcd), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) v = $urandom_range(0, 255) * $urandom_range(0, 255);
      else            v = $urandom_range(0, 65535);
      convert(v, "rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    check_eq("done_pulse_count", done_cnt, accepted);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
